status_flags_reg: RTL and testbench

- Holds the 6502/2A03 processor status register P (N V - B D I Z C).
- Sits directly downstream of the ALU:
  - captures the ALU's negative/overflow/zero/carry results under per-flag update enables;
  - feeds carry and overflow back to the ALU's carryIn/overflowIn.
- Also handles:
  - explicit flag instructions (CLC/SEC/CLI/SEI/CLV/CLD/SED);
  - the BIT, PLP/RTI, PHP/BRK and interrupt-entry paths;
  - branch-condition evaluation;
  - the delayed interrupt-inhibit seen by IRQ polling.

---
 rtl/p6502_pkg.sv | 41 ++++
 rtl/branch_cond_eval.sv | 31 +++
 rtl/status_flags_reg.sv | 133 +++++++++++++
 tb/tb_status_flags_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/p6502_pkg.sv
// Shared 6502/2A03 definitions: status-flag bit positions, flag-instruction
// and branch-select encodings, and the P-register packing helper.
package p6502_pkg;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_I = 2;
  localparam int unsigned FLAG_D = 3;
  localparam int unsigned FLAG_B = 4;
  localparam int unsigned FLAG_U = 5;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  localparam logic [7:0] RESET_P_DEFAULT = 8'h04;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } flag_op_e;

  typedef enum logic [1:0] {
    BR_N = 2'd0,
    BR_V = 2'd1,
    BR_C = 2'd2,
    BR_Z = 2'd3
  } br_sel_e;

  // Bit 5 reads as 1 on the bus; B exists only in the pushed image.
  function automatic logic [7:0] pack_p(input logic n, input logic v, input logic b,
                                        input logic d, input logic i, input logic z,
                                        input logic c);
    return {n, v, 1'b1, b, d, i, z, c};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Conditional-branch decision: select one stored flag by opcode bits 7:6 and
// compare it against opcode bit 5.
module branch_cond_eval
  import p6502_pkg::*;
(
  input  logic       n_i,
  input  logic       v_i,
  input  logic       c_i,
  input  logic       z_i,
  input  logic [1:0] br_sel_i,
  input  logic       br_val_i,
  output logic       taken_o
);

  logic flag_s;

  // 4:1 flag mux on the branch select field
  always_comb begin
    flag_s = 1'b0;
    case (br_sel_e'(br_sel_i))
      BR_N:    flag_s = n_i;
      BR_V:    flag_s = v_i;
      BR_C:    flag_s = c_i;
      BR_Z:    flag_s = z_i;
      default: flag_s = 1'b0;
    endcase
  end

  assign taken_o = (flag_s == br_val_i);

endmodule

// File: rtl/status_flags_reg.sv
// 6502 processor status register P: ALU flag capture, flag instructions,
// BIT/PLP/PHP/interrupt paths, branch evaluation and delayed IRQ inhibit.
module status_flags_reg
  import p6502_pkg::*;
#(
  parameter logic [7:0] RESET_P = RESET_P_DEFAULT,
  parameter bit         I_DELAY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic [2:0] flag_op,
  input  logic       plp_load,
  input  logic [7:0] data_in,
  input  logic       set_i_int,
  input  logic       push_brk,
  input  logic       fetch,
  input  logic [1:0] br_sel,
  input  logic       br_val,
  output logic [7:0] p_out,
  output logic       carry_out,
  output logic       overflow_out,
  output logic       branch_taken,
  output logic       irq_inhibit
);

  logic n_q, v_q, d_q, i_q, z_q, c_q, inh_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, inh_d;
  logic unused_data_s;

  assign unused_data_s = ^data_in[FLAG_U:FLAG_B];

  // Next-state flags; later assignments within the else branch carry higher priority
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (plp_load) begin
      n_d = data_in[FLAG_N];
      v_d = data_in[FLAG_V];
      d_d = data_in[FLAG_D];
      i_d = data_in[FLAG_I];
      z_d = data_in[FLAG_Z];
      c_d = data_in[FLAG_C];
    end else begin
      if (upd_nz) begin
        n_d = alu_n;
        z_d = alu_z;
      end else begin
        n_d = n_q;
        z_d = z_q;
      end
      c_d = upd_c ? alu_c : c_q;
      v_d = upd_v ? alu_v : v_q;
      if (bit_op) begin
        n_d = data_in[FLAG_N];
        v_d = data_in[FLAG_V];
        z_d = alu_z;
      end else begin
        n_d = n_d;
      end
      case (flag_op_e'(flag_op))
        FOP_CLC:  c_d = 1'b0;
        FOP_SEC:  c_d = 1'b1;
        FOP_CLI:  i_d = 1'b0;
        FOP_SEI:  i_d = 1'b1;
        FOP_CLV:  v_d = 1'b0;
        FOP_CLD:  d_d = 1'b0;
        FOP_SED:  d_d = 1'b1;
        default:  c_d = c_d;
      endcase
      i_d = set_i_int ? 1'b1 : i_d;
    end
  end

  // IRQ-polling view of I: sampled at fetch, forced high on interrupt entry
  always_comb begin
    if (set_i_int && !plp_load) begin
      inh_d = 1'b1;
    end else if (fetch) begin
      inh_d = i_q;
    end else begin
      inh_d = inh_q;
    end
  end

  // Flag storage with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q   <= RESET_P[FLAG_N];
      v_q   <= RESET_P[FLAG_V];
      d_q   <= RESET_P[FLAG_D];
      i_q   <= RESET_P[FLAG_I];
      z_q   <= RESET_P[FLAG_Z];
      c_q   <= RESET_P[FLAG_C];
      inh_q <= 1'b1;
    end else begin
      n_q   <= n_d;
      v_q   <= v_d;
      d_q   <= d_d;
      i_q   <= i_d;
      z_q   <= z_d;
      c_q   <= c_d;
      inh_q <= inh_d;
    end
  end

  assign p_out        = pack_p(n_q, v_q, push_brk, d_q, i_q, z_q, c_q);
  assign carry_out    = c_q;
  assign overflow_out = v_q;
  assign irq_inhibit  = I_DELAY ? inh_q : i_q;

  branch_cond_eval u_branch_cond_eval (
    .n_i      (n_q),
    .v_i      (v_q),
    .c_i      (c_q),
    .z_i      (z_q),
    .br_sel_i (br_sel),
    .br_val_i (br_val),
    .taken_o  (branch_taken)
  );

endmodule

// File: tb/tb_status_flags_reg.sv
// Directed scoreboard bench for status_flags_reg (default parameters).
module tb_status_flags_reg;

  logic       clk = 1'b0;
  logic       reset, alu_n, alu_v, alu_z, alu_c, upd_nz, upd_c, upd_v, bit_op;
  logic [2:0] flag_op;
  logic       plp_load, set_i_int, push_brk, fetch, br_val;
  logic [7:0] data_in;
  logic [1:0] br_sel;
  logic [7:0] p_out;
  logic       carry_out, overflow_out, branch_taken, irq_inhibit;

  localparam int K_P = 0, K_C = 1, K_V = 2, K_IRQ = 3, K_BR = 4;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t sb_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  status_flags_reg dut (
    .clk(clk), .reset(reset), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z), .alu_c(alu_c),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op), .flag_op(flag_op),
    .plp_load(plp_load), .data_in(data_in), .set_i_int(set_i_int), .push_brk(push_brk),
    .fetch(fetch), .br_sel(br_sel), .br_val(br_val), .p_out(p_out), .carry_out(carry_out),
    .overflow_out(overflow_out), .branch_taken(branch_taken), .irq_inhibit(irq_inhibit)
  );

  function automatic logic [7:0] observe(input int kind);
    case (kind)
      K_P:     return p_out;
      K_C:     return {7'd0, carry_out};
      K_V:     return {7'd0, overflow_out};
      K_IRQ:   return {7'd0, irq_inhibit};
      default: return {7'd0, branch_taken};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int kind, input logic [7:0] exp);
    sb_t e;
    e.kind = kind;
    e.exp  = exp;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    sb_t        e;
    logic [7:0] o;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = observe(e.kind);
      tests++;
      assert (o === e.exp) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {alu_n, alu_v, alu_z, alu_c, upd_nz, upd_c, upd_v, bit_op} = 8'd0;
    flag_op = 3'd0;
    {plp_load, set_i_int, push_brk, fetch, br_val} = 5'd0;
    data_in = 8'd0;
    br_sel  = 2'd0;
  endtask

  logic exp_taken;
  logic [3:0] nvcz;

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    expect_val("reset_p", K_P, 8'h24);
    expect_val("reset_c", K_C, 8'h00);
    expect_val("reset_v", K_V, 8'h00);
    expect_val("reset_irq", K_IRQ, 8'h01);
    check_all();

    plp_load = 1'b1; data_in = 8'hFF;
    tick();
    expect_val("reset_over_plp", K_P, 8'h24);
    check_all();
    reset = 1'b0; idle_inputs();

    alu_n = 1'b1; alu_z = 1'b0; alu_c = 1'b1; alu_v = 1'b1; upd_nz = 1'b1; upd_c = 1'b1;
    tick();
    expect_val("alu_p", K_P, 8'hA5);
    expect_val("alu_c", K_C, 8'h01);
    expect_val("alu_v_held", K_V, 8'h00);
    check_all();

    idle_inputs();
    alu_n = 1'b0; alu_z = 1'b1; alu_c = 1'b0; alu_v = 1'b0;
    tick();
    expect_val("hold_p", K_P, 8'hA5);
    check_all();

    alu_v = 1'b1; upd_v = 1'b1;
    tick();
    expect_val("upd_v_p", K_P, 8'hE5);
    expect_val("upd_v_ovf", K_V, 8'h01);
    check_all();

    idle_inputs();
    plp_load = 1'b1; data_in = 8'hDB; set_i_int = 1'b1;
    tick();
    expect_val("plp_p", K_P, 8'hEB);
    expect_val("plp_irq", K_IRQ, 8'h01);
    check_all();
    idle_inputs();
    push_brk = 1'b1;
    #1;
    expect_val("php_p", K_P, 8'hFB);
    check_all();
    push_brk = 1'b0;

    flag_op = 3'd1; upd_c = 1'b1; alu_c = 1'b1;
    tick();
    expect_val("clc_vs_upd_c", K_C, 8'h00);
    expect_val("clc_p", K_P, 8'hEA);
    check_all();

    idle_inputs();
    bit_op = 1'b1; data_in = 8'h80; alu_z = 1'b1; upd_nz = 1'b1; alu_n = 1'b0;
    tick();
    expect_val("bit_p", K_P, 8'hAA);
    expect_val("bit_v", K_V, 8'h00);
    check_all();

    idle_inputs();
    flag_op = 3'd6;
    tick();
    expect_val("cld_p", K_P, 8'hA2);
    check_all();

    flag_op = 3'd4;
    tick();
    flag_op = 3'd0; fetch = 1'b1;
    tick();
    fetch = 1'b0;
    expect_val("sei_p", K_P, 8'hA6);
    expect_val("sei_irq", K_IRQ, 8'h01);
    check_all();

    flag_op = 3'd3;
    tick();
    flag_op = 3'd0;
    expect_val("cli_p", K_P, 8'hA2);
    expect_val("cli_irq_delayed", K_IRQ, 8'h01);
    check_all();
    tick();
    expect_val("cli_irq_nofetch", K_IRQ, 8'h01);
    check_all();
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    expect_val("cli_irq_fetch", K_IRQ, 8'h00);
    check_all();

    set_i_int = 1'b1; flag_op = 3'd3;
    tick();
    idle_inputs();
    expect_val("int_entry_p", K_P, 8'hA6);
    expect_val("int_entry_irq", K_IRQ, 8'h01);
    check_all();

    for (int pat = 0; pat < 2; pat++) begin
      plp_load = 1'b1;
      data_in  = (pat == 0) ? 8'h81 : 8'h42;
      nvcz     = (pat == 0) ? 4'b1010 : 4'b0101;
      tick();
      plp_load = 1'b0;
      for (int s = 0; s < 4; s++) begin
        for (int b = 0; b < 2; b++) begin
          br_sel = 2'(s);
          br_val = 1'(b);
          #1;
          exp_taken = (nvcz[3 - s] == br_val);
          expect_val($sformatf("branch_p%0d_s%0d_v%0d", pat, s, b), K_BR, {7'd0, exp_taken});
          check_all();
        end
      end
    end

    upd_c = 1'b1; alu_c = 1'b1; flag_op = 3'd7; reset = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    expect_val("midop_reset_p", K_P, 8'h24);
    expect_val("midop_reset_irq", K_IRQ, 8'h01);
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
